boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_seq_pkg.sv | 26 ++
 rtl/sync2.sv | 24 ++
 rtl/boot_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_boot_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// Shared types for the boot sequencer: FSM state encoding, restart-cause codes and
// small counter helpers.
package boot_seq_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStretch  = 2'd1,
        StRun      = 2'd2,
        StHalt     = 2'd3
    } state_e;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_LOCK = 2'd1;
    localparam logic [1:0] FAULT_BTN  = 2'd2;
    localparam logic [1:0] FAULT_WDT  = 2'd3;

    // Bits needed to hold 0..v, never less than one.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; RESET_VAL sets the level
// presented while reset is asserted.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Core boot sequencer: waits for PLL lock and a released button, stretches core reset,
// then supervises RUN/HALT. Define BOOT_WDT_EN to add the kick-driven watchdog in RUN.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES  = 4194303,
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned WDT_CYCLES      = 67108863
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lock,
    input  logic       btn_n,
    input  logic       terminate,
    input  logic       kick,
    output logic       core_reset,
    output logic       running,
    output logic [1:0] fault,
    output logic [7:0] restart_count
);

    localparam int unsigned SW = cnt_width(STRETCH_CYCLES);
    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

    logic lock_s, btn_s;

    sync2 #(.RESET_VAL(1'b0)) u_sync_lock (
        .clock (clock),
        .reset (reset),
        .d     (lock),
        .q     (lock_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_btn (
        .clock (clock),
        .reset (reset),
        .d     (btn_n),
        .q     (btn_s)
    );

    // Debounced button level, 1 = released.
    logic          btn_deb_q;
    logic [DW-1:0] deb_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_deb_q <= 1'b1;
            deb_cnt_q <= '0;
        end else if (btn_s == btn_deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_deb_q <= btn_s;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
        end
    end

    state_e        state_q, state_d;
    logic [SW-1:0] stretch_q, stretch_d;
    logic [1:0]    fault_q, fault_d;
    logic [7:0]    count_q, count_d;
    logic          core_reset_d, running_d;
    logic          wdt_expired;

`ifdef BOOT_WDT_EN
    localparam int unsigned WW = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES);

    logic [WW-1:0] wdt_q, wdt_d;

    // Held at the load value outside RUN, so RUN always starts with a full timeout.
    always_comb begin
        wdt_d = wdt_q;
        if (state_q != StRun || kick) begin
            wdt_d = WDT_LOAD;
        end else if (wdt_q != '0) begin
            wdt_d = wdt_q - WW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign wdt_expired = (wdt_q == '0);
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    logic unused_kick;
    assign unused_kick = kick;
    assign wdt_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StWaitLock;
            stretch_q  <= '0;
            fault_q    <= FAULT_NONE;
            count_q    <= '0;
            core_reset <= 1'b1;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stretch_q  <= stretch_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
            core_reset <= core_reset_d;
            running    <= running_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        fault_d   = fault_q;
        count_d   = count_q;
        case (state_q)
            StWaitLock: begin
                if (lock_s && btn_deb_q) begin
                    state_d   = StStretch;
                    stretch_d = STRETCH_LOAD;
                end
            end
            StStretch: begin
                if (!lock_s || !btn_deb_q) begin
                    state_d = StWaitLock;
                end else if (stretch_q == '0) begin
                    state_d = StRun;
                end else begin
                    stretch_d = stretch_q - SW'(1);
                end
            end
            StRun: begin
                // Priority: lock loss > button > watchdog > terminate.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    fault_d = FAULT_LOCK;
                    count_d = sat_inc(count_q);
                end else if (!btn_deb_q) begin
                    state_d = StWaitLock;
                    fault_d = FAULT_BTN;
                    count_d = sat_inc(count_q);
                end else if (wdt_expired) begin
                    state_d = StWaitLock;
                    fault_d = FAULT_WDT;
                    count_d = sat_inc(count_q);
                end else if (terminate) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    fault_d = FAULT_LOCK;
                    count_d = sat_inc(count_q);
                end else if (!btn_deb_q) begin
                    state_d = StWaitLock;
                    fault_d = FAULT_BTN;
                    count_d = sat_inc(count_q);
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    always_comb begin
        core_reset_d = 1'b1;
        running_d    = 1'b0;
        if (state_q == StRun) begin
            core_reset_d = 1'b0;
            running_d    = 1'b1;
        end
    end

    assign fault         = fault_q;
    assign restart_count = count_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: stimulus pushes expected output tuples (with the
// cycle they should appear), a monitor pops one on every output change.
module tb_boot_sequencer;

    localparam int unsigned STRETCH = 15;
    localparam int unsigned DEB     = 7;
    localparam int unsigned WDT     = 31;

    logic       clock = 1'b0;
    logic       reset, lock, btn_n, terminate, kick;
    logic       core_reset, running;
    logic [1:0] fault;
    logic [7:0] restart_count;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int sat_c;
    int mark;
    bit kick_en = 1'b0;
    bit mon_on  = 1'b0;

    typedef struct {
        logic [11:0] v;
        int          stamp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] exp_last;
    logic [11:0] prev;
    logic [11:0] mon_cur;

    boot_sequencer #(
        .STRETCH_CYCLES  (STRETCH),
        .DEBOUNCE_CYCLES (DEB),
        .WDT_CYCLES      (WDT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .lock          (lock),
        .btn_n         (btn_n),
        .terminate     (terminate),
        .kick          (kick),
        .core_reset    (core_reset),
        .running       (running),
        .fault         (fault),
        .restart_count (restart_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Expected outputs {core_reset, running, fault, count}; only real changes are queued.
    task automatic exp_out(input logic cr, input logic run, input logic [1:0] f,
                           input logic [7:0] c, input int stamp, input string tag);
        exp_t        e;
        logic [11:0] v;
        v = {cr, run, f, c};
        if (v != exp_last) begin
            e.v     = v;
            e.stamp = stamp;
            e.tag   = tag;
            sb.push_back(e);
            exp_last = v;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every change of the output tuple consumes one scoreboard entry.
    always @(negedge clock) begin
        if (mon_on) begin
            mon_cur = {core_reset, running, fault, restart_count};
            if (mon_cur !== prev) begin
                prev = mon_cur;
                if (sb.size() == 0) begin
                    check("unexpected_change", {20'd0, mon_cur}, {20'd0, exp_last});
                end else begin
                    mon_e = sb.pop_front();
                    check(mon_e.tag, {20'd0, mon_cur}, {20'd0, mon_e.v});
                    if (mon_e.stamp >= 0) check({mon_e.tag, "_cycle"}, cyc, mon_e.stamp);
                end
            end
        end
    end

    // Heartbeat: one-cycle kick every 20 cycles while enabled.
    initial begin
        kick = 1'b0;
        forever begin
            @(negedge clock);
            kick = kick_en && (cyc % 20 == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        lock      = 1'b0;
        btn_n     = 1'b1;
        terminate = 1'b0;
        exp_last  = 12'h800;
        prev      = 12'h800;
        repeat (3) @(negedge clock);
        check("rst_core_reset", {31'd0, core_reset}, 1);
        check("rst_running", {31'd0, running}, 0);
        check("rst_fault", {30'd0, fault}, 0);
        check("rst_count", {24'd0, restart_count}, 0);
        reset   = 1'b1;
        mon_on  = 1'b1;
        kick_en = 1'b1;

        // First boot: 2 sync + 1 accept + 16 stretch + 1 output register = 20 cycles.
        while (cyc < 10) @(negedge clock);
        lock = 1'b1;
        exp_out(1'b0, 1'b1, 2'd0, 8'd0, cyc + 20, "first_boot");
        drain(40);

        // Lock loss in RUN, then relock.
        @(negedge clock);
        lock = 1'b0;
        exp_out(1'b0, 1'b1, 2'd1, 8'd1, cyc + 3, "lockloss_fault");
        exp_out(1'b1, 1'b0, 2'd1, 8'd1, cyc + 4, "lockloss_reset");
        repeat (10) @(negedge clock);
        lock = 1'b1;
        exp_out(1'b0, 1'b1, 2'd1, 8'd1, cyc + 20, "relock_run");
        drain(40);

        // Five-cycle bounces are filtered; eight stable low cycles restart.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            btn_n = 1'b0;
            repeat (5) @(negedge clock);
            btn_n = 1'b1;
            repeat (5) @(negedge clock);
        end
        btn_n = 1'b0;
        exp_out(1'b0, 1'b1, 2'd2, 8'd2, cyc + 10, "btn_fault");
        exp_out(1'b1, 1'b0, 2'd2, 8'd2, cyc + 11, "btn_reset");
        repeat (8) @(negedge clock);
        btn_n = 1'b1;
        exp_out(1'b0, 1'b1, 2'd2, 8'd2, cyc + 27, "btn_run");
        drain(50);

        // Terminate -> HALT, then a press leaves HALT.
        @(negedge clock);
        terminate = 1'b1;
        exp_out(1'b1, 1'b0, 2'd2, 8'd2, cyc + 2, "halt");
        @(negedge clock);
        terminate = 1'b0;
        repeat (10) @(negedge clock);
        btn_n = 1'b0;
        exp_out(1'b1, 1'b0, 2'd2, 8'd3, cyc + 10, "halt_press");
        repeat (10) @(negedge clock);
        btn_n = 1'b1;
        exp_out(1'b0, 1'b1, 2'd2, 8'd3, cyc + 27, "halt_rerun");
        drain(50);

`ifdef BOOT_WDT_EN
        // Regular kicks keep RUN; once they stop, expiry 33 cycles after the last kick.
        repeat (100) @(negedge clock);
        @(negedge clock);
        while (cyc % 20 != 1) @(negedge clock);
        kick_en = 1'b0;
        mark    = cyc - 1;
        exp_out(1'b0, 1'b1, 2'd3, 8'd4, mark + 33, "wdt_fault");
        exp_out(1'b1, 1'b0, 2'd3, 8'd4, mark + 34, "wdt_reset");
        exp_out(1'b0, 1'b1, 2'd3, 8'd4, mark + 52, "wdt_run");
        drain(70);
        kick_en = 1'b1;
`else
        // Without the watchdog, silence on kick changes nothing.
        kick_en = 1'b0;
        repeat (100) @(negedge clock);
        kick_en = 1'b1;
`endif

        // Asynchronous reset mid-run restarts the whole sequence.
        exp_out(1'b1, 1'b0, 2'd0, 8'd0, -1, "async_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_count", {24'd0, restart_count}, 0);
        check("midrst_core_reset", {31'd0, core_reset}, 1);
        reset = 1'b1;
        exp_out(1'b0, 1'b1, 2'd0, 8'd0, cyc + 20, "reboot");
        drain(40);

        // 300 lock-loss restarts: the counter must stop at 255.
        for (int i = 1; i <= 300; i++) begin
            sat_c = (i > 255) ? 255 : i;
            @(negedge clock);
            lock = 1'b0;
            exp_out(1'b0, 1'b1, 2'd1, 8'(sat_c), cyc + 3, "sat_fault");
            exp_out(1'b1, 1'b0, 2'd1, 8'(sat_c), cyc + 4, "sat_reset");
            repeat (6) @(negedge clock);
            lock = 1'b1;
            exp_out(1'b0, 1'b1, 2'd1, 8'(sat_c), cyc + 20, "sat_run");
            drain(40);
        end
        check("final_count", {24'd0, restart_count}, 255);
        check("final_running", {31'd0, running}, 1);

        repeat (5) @(negedge clock);
        check("queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
